// File: rtl/ctrl_out_cfg_seq.sv
// ctrl_out_cfg_seq: glitch-safe sequencer for the ctrl_out0/ctrl_out1 mux configuration words.
// Defers updates while running, blanks changed fields, applies, then acknowledges after settle.
`default_nettype none

module ctrl_out_cfg_seq #(
  parameter int REG_WIDTH           = 32,
  parameter int CTRL_OUT_SRC_BITS   = 5,
  parameter int CTRL_OUT_LEVEL_BITS = 2,
  parameter int NUM_DST             = 4,
  parameter int BLANK_CYCLES        = 4,
  parameter int BLANK_LEVEL         = 0,
  parameter int SETTLE_CYCLES       = 1,
  parameter logic [REG_WIDTH-1:0] RESET_CTRL0 = '0,
  parameter logic [REG_WIDTH-1:0] RESET_CTRL1 = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] cfg0_in,
  input  logic [REG_WIDTH-1:0] cfg1_in,
  input  logic                 cfg_update,
  input  logic                 cfg_force,
  input  logic                 cfg_cancel,
  input  logic                 status_run,
  output logic [REG_WIDTH-1:0] ctrl_out0,
  output logic [REG_WIDTH-1:0] ctrl_out1,
  output logic                 cfg_busy,
  output logic                 cfg_pending,
  output logic                 cfg_done,
  output logic                 cfg_ignored
);

  localparam int FW   = CTRL_OUT_SRC_BITS + CTRL_OUT_LEVEL_BITS;
  localparam int MAXB = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
  localparam int MAXC = (MAXB > 1) ? MAXB : 1;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LOAD  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [FW-1:0] BLANK_FIELD =
    {CTRL_OUT_LEVEL_BITS'(BLANK_LEVEL), CTRL_OUT_SRC_BITS'(0)};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_STOP = 3'd1,
    S_BLANK     = 3'd2,
    S_APPLY     = 3'd3,
    S_SETTLE    = 3'd4
  } state_t;

  state_t               state;
  logic [REG_WIDTH-1:0] shadow0, shadow1;
  logic [NUM_DST-1:0]   mask0, mask1;
  logic [CW-1:0]        cnt;
  logic                 ign_late;

  logic [REG_WIDTH-1:0] cand0, cand1, blank0, blank1;
  logic [NUM_DST-1:0]   new_mask0, new_mask1;
  logic                 same, go, finish, seq_active;

  // A request arriving this edge replaces the shadow, so compare against it directly.
  assign cand0 = cfg_update ? cfg0_in : shadow0;
  assign cand1 = cfg_update ? cfg1_in : shadow1;
  assign same  = (cand0 == ctrl_out0) && (cand1 == ctrl_out1);

  always_comb begin
    new_mask0 = '0;
    new_mask1 = '0;
    blank0    = ctrl_out0;
    blank1    = ctrl_out1;
    for (int i = 0; i < NUM_DST; i++) begin
      new_mask0[i] = cand0[i*FW +: FW] != ctrl_out0[i*FW +: FW];
      new_mask1[i] = cand1[i*FW +: FW] != ctrl_out1[i*FW +: FW];
      if (mask0[i]) blank0[i*FW +: FW] = BLANK_FIELD;
      if (mask1[i]) blank1[i*FW +: FW] = BLANK_FIELD;
    end
  end

  always_comb begin
    go = 1'b0;
    if (state == S_IDLE)
      go = cfg_update && (cfg_force || !status_run);
    else if (state == S_WAIT_STOP)
      go = !cfg_cancel && ((cfg_update && cfg_force) || !status_run);
  end

  assign finish     = ((state == S_APPLY) && (SETTLE_CYCLES == 0)) ||
                      ((state == S_SETTLE) && (cnt == '0));
  assign seq_active = (state == S_BLANK) || (state == S_APPLY) || (state == S_SETTLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      shadow0     <= '0;
      shadow1     <= '0;
      mask0       <= '0;
      mask1       <= '0;
      cnt         <= '0;
      ign_late    <= 1'b0;
      ctrl_out0   <= RESET_CTRL0;
      ctrl_out1   <= RESET_CTRL1;
      cfg_busy    <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_ignored <= 1'b0;
    end else begin
      cfg_done    <= 1'b0;
      cfg_ignored <= 1'b0;
      case (state)
        S_IDLE, S_WAIT_STOP: begin
          // A request dropped on the completion edge is reported here so it never overlaps cfg_done.
          cfg_ignored <= ign_late;
          ign_late    <= 1'b0;
          if (cfg_update) begin
            shadow0 <= cfg0_in;
            shadow1 <= cfg1_in;
          end
          if (go) begin
            mask0       <= new_mask0;
            mask1       <= new_mask1;
            cfg_pending <= 1'b0;
            if (same) begin
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              cfg_busy <= 1'b1;
              if (BLANK_CYCLES == 0) begin
                state <= S_APPLY;
              end else begin
                state <= S_BLANK;
                cnt   <= BLANK_LOAD;
              end
            end
          end else if ((state == S_WAIT_STOP) && cfg_cancel) begin
            state       <= S_IDLE;
            cfg_busy    <= 1'b0;
            cfg_pending <= 1'b0;
          end else if ((state == S_IDLE) && cfg_update) begin
            state       <= S_WAIT_STOP;
            cfg_busy    <= 1'b1;
            cfg_pending <= 1'b1;
          end
        end
        S_BLANK: begin
          ctrl_out0 <= blank0;
          ctrl_out1 <= blank1;
          if (cnt == '0) state <= S_APPLY;
          else           cnt   <= cnt - 1'b1;
        end
        S_APPLY: begin
          ctrl_out0 <= shadow0;
          ctrl_out1 <= shadow1;
          if (SETTLE_CYCLES == 0) begin
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            state <= S_SETTLE;
            cnt   <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            cfg_done <= 1'b1;
            cfg_busy <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          cfg_busy    <= 1'b0;
          cfg_pending <= 1'b0;
        end
      endcase
      if (seq_active && cfg_update) begin
        if (finish) ign_late    <= 1'b1;
        else        cfg_ignored <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_out_cfg_seq.sv
// tb_ctrl_out_cfg_seq: directed and randomized checks of ctrl_out_cfg_seq against a timeline model.
`default_nettype none
`timescale 1ns/1ps

module tb_ctrl_out_cfg_seq;

  localparam int B = 4;
  localparam int S = 1;
  localparam logic [6:0] BF = 7'h00;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cfg0_in = '0, cfg1_in = '0;
  logic        cfg_update = 1'b0, cfg_force = 1'b0, cfg_cancel = 1'b0, status_run = 1'b0;
  logic [31:0] ctrl_out0, ctrl_out1, nb_out0, nb_out1;
  logic        cfg_busy, cfg_pending, cfg_done, cfg_ignored;
  logic        nb_busy, nb_pending, nb_done, nb_ignored;

  always #5 clock = ~clock;

  ctrl_out_cfg_seq dut (
    .clock(clock), .reset_n(reset_n), .cfg0_in(cfg0_in), .cfg1_in(cfg1_in),
    .cfg_update(cfg_update), .cfg_force(cfg_force), .cfg_cancel(cfg_cancel),
    .status_run(status_run), .ctrl_out0(ctrl_out0), .ctrl_out1(ctrl_out1),
    .cfg_busy(cfg_busy), .cfg_pending(cfg_pending), .cfg_done(cfg_done),
    .cfg_ignored(cfg_ignored)
  );

  ctrl_out_cfg_seq #(.BLANK_CYCLES(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .cfg0_in(cfg0_in), .cfg1_in(cfg1_in),
    .cfg_update(cfg_update), .cfg_force(cfg_force), .cfg_cancel(cfg_cancel),
    .status_run(status_run), .ctrl_out0(nb_out0), .ctrl_out1(nb_out1),
    .cfg_busy(nb_busy), .cfg_pending(nb_pending), .cfg_done(nb_done),
    .cfg_ignored(nb_ignored)
  );

  int checks = 0, passes = 0, done_seen = 0;

  // Timeline model: 0 idle, 1 pending, 2 sequence launched at edge m_l.
  int          m_mode, m_l, n;
  logic [31:0] sh0, sh1, old0, old1, e0, e1;
  logic        e_done, e_ign;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
  endtask

  function automatic logic [31:0] blanked(logic [31:0] o, logic [31:0] w);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++)
      if (o[7*i +: 7] != w[7*i +: 7]) r[7*i +: 7] = BF;
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_l = 0;
    sh0 = '0; sh1 = '0; e0 = '0; e1 = '0;
    e_done = 1'b0; e_ign = 1'b0;
  endtask

  task automatic launch();
    if (sh0 == e0 && sh1 == e1) begin
      e_done = 1'b1;
      m_mode = 0;
    end else begin
      m_mode = 2; m_l = n; old0 = e0; old1 = e1;
    end
  endtask

  task automatic model_step();
    n++;
    e_done = 1'b0; e_ign = 1'b0;
    case (m_mode)
      0: if (cfg_update) begin
           sh0 = cfg0_in; sh1 = cfg1_in;
           if (status_run && !cfg_force) m_mode = 1;
           else launch();
         end
      1: if (cfg_cancel) m_mode = 0;
         else begin
           if (cfg_update) begin sh0 = cfg0_in; sh1 = cfg1_in; end
           if ((cfg_update && cfg_force) || !status_run) launch();
         end
      default: begin
        if (cfg_update) e_ign = 1'b1;
        if (n > m_l && n <= m_l + B) begin
          e0 = blanked(old0, sh0); e1 = blanked(old1, sh1);
        end
        if (n == m_l + B + 1) begin e0 = sh0; e1 = sh1; end
        if (n == m_l + B + 1 + S) begin e_done = 1'b1; m_mode = 0; end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("ctrl_out0", ctrl_out0, e0);
    chk("ctrl_out1", ctrl_out1, e1);
    chk("cfg_busy", 32'(cfg_busy), 32'(m_mode != 0));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_mode == 1));
    chk("cfg_done", 32'(cfg_done), 32'(e_done));
    chk("cfg_ignored", 32'(cfg_ignored), 32'(e_ign));
    if (cfg_done) done_seen++;
  endtask

  task automatic drive(bit u, bit f, bit c, bit r, logic [31:0] w0, logic [31:0] w1);
    cfg_update = u; cfg_force = f; cfg_cancel = c; status_run = r;
    cfg0_in = w0; cfg1_in = w1;
    cycle();
  endtask

  task automatic idle(int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0, status_run, cfg0_in, cfg1_in);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] mutate(logic [31:0] b);
    logic [31:0] r = b;
    for (int i = 0; i < 4; i++)
      if ($urandom % 3 == 0) r[7*i +: 7] = 7'($urandom);
    if ($urandom % 8 == 0) r[31:28] = 4'($urandom);
    return r;
  endfunction

  initial begin
    n = 0;
    do_reset();
    chk("reset ctrl_out0", ctrl_out0, 32'h0);
    chk("reset busy", 32'(cfg_busy), 32'h0);

    // Idle update from zero to field0 = fixed high.
    drive(1, 0, 0, 0, 32'h0000_0021, 32'h0);
    chk("E0 busy", 32'(cfg_busy), 32'h1);
    chk("nb E0 out0", nb_out0, 32'h0);
    idle(1);
    chk("E1 blank out0", ctrl_out0, 32'h0);
    chk("nb E1 out0", nb_out0, 32'h0000_0021);
    chk("nb E1 done", 32'(nb_done), 32'h0);
    idle(1);
    chk("nb E2 done", 32'(nb_done), 32'h1);
    idle(2);
    chk("E4 blank out0", ctrl_out0, 32'h0);
    idle(1);
    chk("E5 out0", ctrl_out0, 32'h0000_0021);
    chk("E5 done", 32'(cfg_done), 32'h0);
    idle(1);
    chk("E6 done", 32'(cfg_done), 32'h1);
    idle(2);

    // Collision during BLANK: second request ignored, first request wins.
    drive(1, 0, 0, 0, 32'h0000_0042, 32'h1000_0000);
    drive(1, 0, 0, 0, 32'h0000_007f, 32'h0);
    chk("collision ignored", 32'(cfg_ignored), 32'h1);
    chk("blank keeps nibble", ctrl_out1, 32'h0);
    idle(6);
    chk("collision out0", ctrl_out0, 32'h0000_0042);
    chk("collision out1", ctrl_out1, 32'h1000_0000);

    // No-change request.
    drive(1, 0, 0, 0, 32'h0000_0042, 32'h1000_0000);
    chk("nochange done", 32'(cfg_done), 32'h1);
    chk("nochange busy", 32'(cfg_busy), 32'h0);
    idle(2);

    // Reset in the middle of BLANK.
    drive(1, 0, 0, 0, 32'h0000_0021, 32'h1000_0000);
    idle(2);
    chk("midblank out0", ctrl_out0, 32'h0);
    chk("midblank out1", ctrl_out1, 32'h1000_0000);
    reset_n = 1'b0;
    #1;
    chk("async rst out1", ctrl_out1, 32'h0);
    chk("async rst busy", 32'(cfg_busy), 32'h0);
    chk("async rst done", 32'(cfg_done), 32'h0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);

    // Deferred update, latest wins.
    done_seen = 0;
    drive(1, 0, 0, 1, 32'h0, 32'h0000_0001);
    chk("deferred pending", 32'(cfg_pending), 32'h1);
    idle(100);
    drive(1, 0, 0, 1, 32'h0, 32'h0000_0002);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    idle(12);
    chk("deferred out1", ctrl_out1, 32'h0000_0002);
    chk("deferred done count", 32'(done_seen), 32'h1);

    // Forced update while running.
    drive(1, 1, 0, 1, 32'h0000_0005, 32'h0000_0002);
    chk("force busy", 32'(cfg_busy), 32'h1);
    chk("force pending", 32'(cfg_pending), 32'h0);
    idle(10);
    chk("force out0", ctrl_out0, 32'h0000_0005);

    // Cancel together with the status_run fall.
    done_seen = 0;
    drive(1, 0, 0, 1, 32'h0000_0006, 32'h0000_0002);
    idle(3);
    drive(0, 0, 1, 0, 32'h0, 32'h0);
    chk("cancel busy", 32'(cfg_busy), 32'h0);
    idle(10);
    chk("cancel done count", 32'(done_seen), 32'h0);
    chk("cancel out0", ctrl_out0, 32'h0000_0005);

    // Randomized traffic; updates are kept off the completion edge.
    status_run = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit u, r;
      r = ($urandom % 20 == 0) ? !status_run : status_run;
      u = ($urandom % 6 == 0) && !(m_mode == 2 && n + 1 == m_l + B + 1 + S);
      drive(u, ($urandom % 4 == 0), ($urandom % 10 == 0), r, mutate(e0), mutate(e1));
    end
    idle(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
